// File: rtl/first_match_mon.sv
// First-match latency monitor: each start opens a window [MIN_DLY, MAX_DLY] clocks
// wide; the first done inside it reports a match with its latency, otherwise a fail.
module first_match_mon #(
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dis,
    input  logic             start,
    input  logic             done,
    output logic             busy,
    output logic             match,
    output logic             fail,
    output logic [7:0]       lat,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] ovl_cnt
);

    if (MIN_DLY < 1 || MIN_DLY > MAX_DLY || MAX_DLY > 255 || CNT_W < 1) begin : g_bad_params
        $error("first_match_mon: illegal MIN_DLY/MAX_DLY/CNT_W");
    end

    localparam logic [7:0] MIN_C = 8'(MIN_DLY);
    localparam logic [7:0] MAX_C = 8'(MAX_DLY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        WIN  = 2'd2
    } state_t;

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic             r_match;
    logic             r_fail;
    logic [7:0]       r_lat;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic [CNT_W-1:0] r_ovl_cnt;

    // Statistics stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 8'd0;
            r_match    <= 1'b0;
            r_fail     <= 1'b0;
            r_lat      <= 8'd0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_ovl_cnt  <= '0;
        end else begin
            r_match <= 1'b0;
            r_fail  <= 1'b0;
            if (dis) begin
                r_state <= IDLE;
                r_cnt   <= 8'd0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_cnt   <= 8'd1;
                            r_state <= (MIN_DLY > 1) ? HOLD : WIN;
                        end
                    end
                    HOLD: begin
                        if (start) r_ovl_cnt <= sat_inc(r_ovl_cnt);
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt + 8'd1 == MIN_C) r_state <= WIN;
                    end
                    WIN: begin
                        // A start on the terminating edge is still an overlap.
                        if (start) r_ovl_cnt <= sat_inc(r_ovl_cnt);
                        if (done) begin
                            r_match    <= 1'b1;
                            r_lat      <= r_cnt;
                            r_pass_cnt <= sat_inc(r_pass_cnt);
                            r_cnt      <= 8'd0;
                            r_state    <= IDLE;
                        end else if (r_cnt == MAX_C) begin
                            r_fail     <= 1'b1;
                            r_fail_cnt <= sat_inc(r_fail_cnt);
                            r_cnt      <= 8'd0;
                            r_state    <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= 8'd0;
                    end
                endcase
            end
        end
    end

    assign busy     = (r_state != IDLE);
    assign match    = r_match;
    assign fail     = r_fail;
    assign lat      = r_lat;
    assign pass_cnt = r_pass_cnt;
    assign fail_cnt = r_fail_cnt;
    assign ovl_cnt  = r_ovl_cnt;

endmodule

// File: doc/first_match_mon.md
FIRST_MATCH_MON -- requirements
Module: first_match_mon

Interface
REQ-001 The block SHALL have parameter MIN_DLY, default 1, meaning the earliest legal start-to-done delay in clocks (legal range 1..MAX_DLY).
REQ-002 The block SHALL have parameter MAX_DLY, default 4, meaning the latest legal start-to-done delay in clocks (legal range MIN_DLY..255).
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of the pass and fail statistics counters.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 Port: clk  input  1  single clock; all state updates on the posedge.
REQ-006 Port: rst  input  1  asynchronous, active-high reset.
REQ-007 Port: dis  input  1  disable-iff; high aborts any attempt.
REQ-008 Port: start  input  1  sampled request; opens one attempt.
REQ-009 Port: done  input  1  sampled completion.
REQ-010 Port: busy  output  1  high while an attempt is open.
REQ-011 Port: match  output  1  one-cycle pulse, first done inside the window.
REQ-012 Port: fail  output  1  one-cycle pulse, window expired without done.
REQ-013 Port: lat  output  8  delay of the last match, held until the next match.
REQ-014 Port: pass_cnt  output  CNT_W  saturating count of matches.
REQ-015 Port: fail_cnt  output  CNT_W  saturating count of fails.
REQ-016 Port: ovl_cnt  output  CNT_W  saturating count of start pulses ignored while busy.

Function
REQ-017 The FSM SHALL have three states: IDLE, HOLD (delay < MIN_DLY) and WIN (MIN_DLY <= delay <= MAX_DLY); busy = (state != IDLE).
REQ-018 IDLE: on a posedge with start=1 and dis=0, the FSM SHALL load the delay counter to 1 and enter HOLD if MIN_DLY>1, else WIN.
REQ-019 HOLD: each posedge SHALL increment the counter; done is ignored; the FSM enters WIN when the counter reaches MIN_DLY.
REQ-020 WIN: a posedge with done=1 SHALL pulse match the next cycle, load lat with the counter, increment pass_cnt, and return to IDLE (first_match: later dones are ignored).
REQ-021 WIN: a posedge with done=0 and counter==MAX_DLY SHALL pulse fail the next cycle, increment fail_cnt, and return to IDLE.
REQ-022 WIN: a posedge with done=0 and counter<MAX_DLY SHALL increment the counter.
REQ-023 start=1 while busy and not terminating SHALL be ignored, and ovl_cnt SHALL increment.
REQ-024 start=1 on the posedge where the attempt terminates (match or fail) SHALL NOT open a new attempt; it counts as overlap. Back-to-back attempts need start re-asserted in IDLE.
REQ-025 dis=1 on any posedge SHALL force IDLE with no match, fail or counter updates, and SHALL block new starts.
REQ-026 Statistics counters SHALL saturate at all-ones and never wrap.
REQ-027 match and fail SHALL never be high in the same cycle; each is high for exactly one cycle per attempt.
REQ-028 The counter SHALL be 8 bits; MIN_DLY/MAX_DLY outside legal ranges SHALL be rejected at elaboration.

Reset
REQ-029 rst=1 SHALL immediately force: state IDLE; busy, match, fail = 0; lat = 0; all statistics counters = 0; delay counter = 0.
REQ-030 rst asserted mid-attempt SHALL discard the attempt with no match or fail pulse; the first start sampled after rst deasserts SHALL be honoured.

Verification
REQ-031 MIN=1, MAX=4: start at cycle 1, done at cycle 4 -> match at cycle 5, lat=3, pass_cnt=1, fail_cnt=0.
REQ-032 MIN=2, MAX=4: start at cycle 1, done at cycles 2 and 6 only -> early done ignored, fail at cycle 6, fail_cnt=1.
REQ-033 MIN=1, MAX=4: start at cycle 1, done at cycles 2, 3 and 4 -> exactly one match at cycle 3, lat=1, pass_cnt=1.
REQ-034 start at cycles 1 and 3, done at 4 -> one match, ovl_cnt=1; dis=1 at cycle 2 in a second run -> busy drops, no pulse, counters unchanged.
REQ-035 CNT_W=2: 5 consecutive failing attempts -> fail_cnt saturates at 3; rst pulse mid-attempt -> all outputs 0, no pulse.
